pkt_134b_rr_arbiter: RTL
========================

// Module: pkt_134b_rr_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter: shares one 134b packet bus toward the PE among N_SRC
//  134b packet sources (gmii accumulators, DMA, loopback). Grants one source per packet, holds
//  the grant until the tail beat, forwards beats and length one cycle later, and reclaims a
//  stalled grant with a watchdog.
//  134b format: [133:132] tag (01 head, 10 tail); [131:128] valid; [127:0] data.
// PARAMETERS
//  N_SRC        4     number of sources, 2..8
//  TIMEOUT_CYC  4096  idle cycles in a granted packet before the grant is revoked
// PORTS
//  clk             in   1          clock
//  rst_n           in   1          reset, asynchronous, active-low
//  src_req         in   N_SRC      source i holds >=1 complete packet (length FIFO not empty)
//  src_ready       out  N_SRC      per-cycle read enable to the granted source
//  src_data        in   N_SRC*134  source beats; slice i = [134*i+:134]
//  src_data_valid  in   N_SRC      beat valid, 1 cycle after that source's src_ready
//  src_length      in   N_SRC*16   packet length, valid with the head beat
//  ready_in        in   1          downstream may accept beats
//  pkt_data        out  134        forwarded beat
//  pkt_data_valid  out  1          forwarded beat valid
//  pkt_length      out  16         length of the current packet
//  grant_id        out  3          index of the current/last grant
//  timeout_pulse   out  1          1-cycle pulse when a grant is revoked by the watchdog
//  cnt_pkt         out  32         packets granted since reset (wraps)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr=0, watchdog=0.
//  IDLE: if ready_in && |src_req -> pick the first requester at or after rr_ptr (wrapping);
//   grant_id<=pick; cnt_pkt++; -> XFER. Otherwise stay; src_ready=0.
//  XFER: src_ready = onehot(grant_id) & {N_SRC{ready_in}} (combinational from regs + ready_in).
//   Each valid beat from the granted source: pkt_data<=beat, pkt_data_valid<=1 on the next edge
//   (1-cycle latency). If tag==01, pkt_length<=src_length slice. Watchdog cleared on every
//   granted valid beat; otherwise incremented.
//   Valid beat with tag==10 -> rr_ptr<=grant_id+1 (mod N_SRC); -> GAP.
//   Watchdog==TIMEOUT_CYC-1 with no beat -> timeout_pulse=1; rr_ptr<=grant_id+1; -> GAP.
//   No tail beat is fabricated.
//  GAP: src_ready=0; pkt_data_valid<=0; single cycle; -> IDLE. Enforces >=1 idle cycle between
//   packets so the source's read FSM settles.
//  Backpressure: ready_in low drops src_ready in the same cycle. A source beat already in flight
//   (valid one cycle after the last ready) is still forwarded. Downstream must absorb 1 beat
//   after deasserting ready_in, the same contract the sources offer.
//  Beats whose valid is set for a non-granted source are ignored and never forwarded.
//  src_req dropping during XFER has no effect; only tail or timeout ends the grant.
//  pkt_data holds its last value when valid=0. pkt_length holds until the next head.
//  Reset mid-packet: immediate return to reset values; a partial packet is not completed.
//  Arithmetic: rr_ptr wraps at N_SRC (not a power of 2 in general); watchdog is
//   $clog2(TIMEOUT_CYC) bits and saturates at terminal count; cnt_pkt wraps at 2^32.
// STRUCTURE
//  Shared package/header: TAG_HEAD=2'b01, TAG_TAIL=2'b10, PKT_W=134, LEN_W=16, state
//   encodings IDLE/XFER/GAP.
//  One sub-module, rr_pick_n: combinational first-set search from rr_ptr over src_req,
//   returning pick index and found flag. The FSM, watchdog and output registers stay in top.
// TESTING
//  1 src0 only, 3-beat pkt len=40, ready_in=1 -> src_ready[0] high from cycle after grant;
//    out beats tags 01,00,10 one cycle after inputs; pkt_length=40; cnt_pkt=1.
//  2 all 4 srcs requesting, 1-beat pkts each -> grant order 0,1,2,3,0; >=1 idle cycle
//    between packets.
//  3 ready_in low 5 cycles mid-packet -> src_ready low same cycle; exactly one in-flight
//    beat forwarded; resumes with no beat loss or duplication.
//  4 granted src stops after head, TIMEOUT_CYC=16 -> timeout_pulse on 16th idle cycle;
//    next grant goes to grant_id+1; no tail emitted.
//  5 src2 drives valid while src1 is granted -> src2 beats never appear on pkt_data.
//  6 rst_n low mid-XFER -> all outputs 0 asynchronously; after release, grant restarts from
//    src0.

Source files
------------

// File: rtl/pkt_134b_rr_arbiter_pkg.sv
// Shared beat format, tag codes and arbiter state encoding for the packet RR arbiter.
package pkt_134b_rr_arbiter_pkg;
  localparam int PKT_W = 134;
  localparam int LEN_W = 16;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef struct packed {
    logic [1:0]   tag;
    logic [3:0]   vld;
    logic [127:0] data;
  } pkt_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/pkt_134b_rr_arbiter_pick.sv
// First-set search over req starting at ptr and wrapping at N (N need not be a power of 2).
module rr_pick_n #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] pick,
  output logic          found
);
  int idx;

  // Scan from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) pick = IW'(idx);
    end
  end

  assign found = |req;
endmodule

// File: rtl/pkt_134b_rr_arbiter.sv
// Packet-granular round-robin arbiter: one grant per packet, held to the tail beat,
// with a watchdog that revokes a stalled grant.
module pkt_134b_rr_arbiter
  import pkt_134b_rr_arbiter_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       src_req,
  output logic [N_SRC-1:0]       src_ready,
  input  logic [N_SRC*PKT_W-1:0] src_data,
  input  logic [N_SRC-1:0]       src_data_valid,
  input  logic [N_SRC*LEN_W-1:0] src_length,
  input  logic                   ready_in,
  output logic [PKT_W-1:0]       pkt_data,
  output logic                   pkt_data_valid,
  output logic [LEN_W-1:0]       pkt_length,
  output logic [2:0]             grant_id,
  output logic                   timeout_pulse,
  output logic [31:0]            cnt_pkt
);
  localparam int IW   = $clog2(N_SRC);
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_TC = WD_W'(TIMEOUT_CYC - 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr;
  logic [WD_W-1:0] wd_q;
  logic [IW-1:0]   gid, pick, ptr_inc;
  logic            found, dv_g;
  pkt_beat_t       beat_g;
  logic [LEN_W-1:0] len_g;

  rr_pick_n #(.N(N_SRC)) u_pick (
    .req   (src_req),
    .ptr   (rr_ptr),
    .pick  (pick),
    .found (found)
  );

  assign gid     = grant_id[IW-1:0];
  assign beat_g  = src_data[int'(gid)*PKT_W +: PKT_W];
  assign len_g   = src_length[int'(gid)*LEN_W +: LEN_W];
  assign dv_g    = (state_q == ST_XFER) && src_data_valid[gid];
  assign ptr_inc = (gid == IW'(N_SRC - 1)) ? '0 : gid + IW'(1);

  always_comb begin
    state_d       = state_q;
    src_ready     = '0;
    timeout_pulse = 1'b0;
    case (state_q)
      ST_IDLE: if (ready_in && found) state_d = ST_XFER;
      ST_XFER: begin
        src_ready = (N_SRC'(1) << gid) & {N_SRC{ready_in}};
        if (dv_g && beat_g.tag == TAG_TAIL) begin
          state_d = ST_GAP;
        end else if (!dv_g && wd_q == WD_TC) begin
          timeout_pulse = 1'b1;
          state_d       = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rr_ptr         <= '0;
      wd_q           <= '0;
      grant_id       <= '0;
      cnt_pkt        <= '0;
      pkt_data       <= '0;
      pkt_data_valid <= 1'b0;
      pkt_length     <= '0;
    end else begin
      state_q        <= state_d;
      pkt_data_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wd_q <= '0;
          if (ready_in && found) begin
            grant_id <= 3'(pick);
            cnt_pkt  <= cnt_pkt + 32'd1;
          end
        end
        ST_XFER: begin
          // In-flight beats still land here after ready_in drops.
          if (dv_g) begin
            pkt_data       <= beat_g;
            pkt_data_valid <= 1'b1;
            wd_q           <= '0;
            if (beat_g.tag == TAG_HEAD) pkt_length <= len_g;
          end else if (wd_q != WD_TC) begin
            wd_q <= wd_q + WD_W'(1);
          end
          if (state_d == ST_GAP) rr_ptr <= ptr_inc;
        end
        default: wd_q <= '0;
      endcase
    end
  end
endmodule
